// File: rtl/shift_pkg.sv
// shift_pkg: shared widths, op encoding and result record for the EX shift stage
package shift_pkg;
  localparam int XLEN_C = 32;
  localparam int SHAMT_W_C = 5;
  localparam int TAG_W_C = 5;
  typedef enum logic [1:0] {SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_RSVD} shift_op_e;
  typedef struct packed {
    logic [XLEN_C-1:0] data;
    logic [TAG_W_C-1:0] tag;
  } shift_res_t;
endpackage

// File: rtl/shift_core.sv
// shift_core: combinational log-depth barrel shifter (16/8/4/2/1) for SLL/SRL/SRA
module shift_core
  import shift_pkg::*;
(
  input  shift_op_e              op_i,
  input  logic [XLEN_C-1:0]      rs1_i,
  input  logic [SHAMT_W_C-1:0]   shamt_i,
  output logic [XLEN_C-1:0]      res_o
);
  logic left, fill;
  logic [SHAMT_W_C:0][XLEN_C-1:0] st;
  assign left = op_i == SHIFT_SLL;
  assign fill = op_i == SHIFT_SRA && rs1_i[XLEN_C-1];
  assign st[0] = rs1_i;
  for (genvar i = 0; i < SHAMT_W_C; i++) begin : g_stage
    localparam int S = 1 << (SHAMT_W_C - 1 - i);
    assign st[i+1] = !shamt_i[SHAMT_W_C-1-i] ? st[i] :
                     left ? {st[i][XLEN_C-1-S:0], {S{1'b0}}} :
                            {{S{fill}}, st[i][XLEN_C-1:S]};
  end
  assign res_o = op_i == SHIFT_RSVD ? '0 : st[SHAMT_W_C];
endmodule

// File: rtl/ex_shift_stage.sv
// ex_shift_stage: registered EX shift unit with valid/ready handshake and one-entry skid buffer
module ex_shift_stage
  import shift_pkg::*;
#(
  parameter int XLEN  = XLEN_C,
  parameter int TAG_W = TAG_W_C
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  rd_o,
  output logic [TAG_W-1:0] tag_o
);
  shift_res_t out_q, out_d, skid_q, skid_d, new_res;
  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic acc, xfer, unused_rs2;
  logic [XLEN-1:0] res;
  shift_core u_core (
    .op_i   (shift_op_e'(op_i)),
    .rs1_i  (rs1_i),
    .shamt_i(rs2_i[SHAMT_W_C-1:0]),
    .res_o  (res)
  );
  assign unused_rs2 = ^rs2_i[XLEN-1:SHAMT_W_C];
  assign new_res = '{data: res, tag: tag_i};
  // Ready depends only on the skid register, never on out_ready_i.
  assign in_ready_o = !skid_valid_q;
  assign acc = in_valid_i && in_ready_o;
  assign xfer = out_valid_q && out_ready_i;
  assign out_valid_o = out_valid_q;
  assign rd_o = out_q.data;
  assign tag_o = out_q.tag;
  always_comb begin
    out_d = out_q;
    out_valid_d = out_valid_q;
    skid_d = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || xfer) begin
      out_valid_d = skid_valid_q || acc;
      out_d = skid_valid_q ? skid_q : acc ? new_res : out_q;
      skid_valid_d = 1'b0;
    end else if (acc) begin
      skid_d = new_res;
      skid_valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
      out_valid_q <= 1'b0;
      skid_q <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q <= out_d;
      out_valid_q <= out_valid_d;
      skid_q <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
endmodule

// File: tb/tb_ex_shift_stage.sv
// tb_ex_shift_stage: directed + random scoreboard bench for ex_shift_stage
module tb_ex_shift_stage;
  logic clk_i = 1'b0, rst_ni, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [1:0] op_i;
  logic [31:0] rs1_i, rs2_i, rd_o;
  logic [4:0] tag_i, tag_o;
  int n_cmp = 0, n_mis = 0;
  logic [36:0] sb[$];
  ex_shift_stage dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .rd_o(rd_o), .tag_o(tag_o)
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [31:0] ref_f(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      2'd0: return a << sh;
      2'd1: return a >> sh;
      2'd2: return $signed(a) >>> sh;
      default: return 32'd0;
    endcase
  endfunction
  task automatic chk(string n, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %h want %h", n, obs, exp);
    end
  endtask
  task automatic cyc(output bit acc);
    logic [36:0] e;
    acc = in_valid_i && in_ready_o;
    if (out_valid_o && out_ready_i && sb.size() != 0) void'(sb.pop_front());
    if (flush_i) sb.delete();
    else if (acc) sb.push_back({ref_f(op_i, rs1_i, rs2_i), tag_i});
    @(posedge clk_i);
    #1;
    chk("out_valid", {31'd0, out_valid_o}, {31'd0, sb.size() != 0});
    chk("in_ready", {31'd0, in_ready_o}, {31'd0, sb.size() < 2});
    if (out_valid_o && sb.size() != 0) begin
      e = sb[0];
      chk("rd", rd_o, e[36:5]);
      chk("tag", {27'd0, tag_o}, {27'd0, e[4:0]});
    end
  endtask
  task automatic idle(int n);
    bit a;
    in_valid_i = 1'b0;
    repeat (n) cyc(a);
  endtask
  task automatic send(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] t);
    bit acc;
    int k = 0;
    op_i = op; rs1_i = a; rs2_i = b; tag_i = t; in_valid_i = 1'b1;
    do begin
      cyc(acc);
      k++;
    end while (!acc && k < 50);
    in_valid_i = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask
  initial begin
    bit acc;
    int ops = 0, cycles = 0;
    logic r0;
    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    op_i = '0; rs1_i = '0; rs2_i = '0; tag_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_ready", {31'd0, in_ready_o}, 32'd1);
    chk("rst_rd", rd_o, 32'd0);
    chk("rst_tag", {27'd0, tag_o}, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    // back-to-back SRA then SRL
    send(2'd2, 32'h8000_0000, 32'd4, 5'd3);
    chk("sra_rd", rd_o, 32'hF800_0000);
    send(2'd1, 32'h8000_0000, 32'd4, 5'd4);
    chk("srl_rd", rd_o, 32'h0800_0000);
    chk("b2b_valid", {31'd0, out_valid_o}, 32'd1);
    idle(2);
    // shift-amount masking and reserved op
    send(2'd0, 32'h1, 32'hFFFF_FFE3, 5'd5);
    chk("mask_rd", rd_o, 32'h8);
    send(2'd2, 32'hFFFF_FFFF, 32'd31, 5'd6);
    chk("sra31_rd", rd_o, 32'hFFFF_FFFF);
    send(2'd3, 32'h1234_5678, 32'd1, 5'd7);
    chk("rsvd_rd", rd_o, 32'd0);
    chk("rsvd_tag", {27'd0, tag_o}, 32'd7);
    idle(2);
    // backpressure: A, B fill output and skid; C held until drain
    out_ready_i = 1'b0;
    send(2'd0, 32'hA, 32'd1, 5'd1);
    send(2'd0, 32'hB, 32'd1, 5'd2);
    chk("bp_ready", {31'd0, in_ready_o}, 32'd0);
    op_i = 2'd1; rs1_i = 32'hC0; rs2_i = 32'd4; tag_i = 5'd3; in_valid_i = 1'b1;
    cyc(acc);
    chk("bp_hold", {31'd0, acc}, 32'd0);
    out_ready_i = 1'b1;
    send(2'd1, 32'hC0, 32'd4, 5'd3);
    idle(3);
    // flush with output and skid full
    out_ready_i = 1'b0;
    send(2'd0, 32'h11, 32'd2, 5'd10);
    send(2'd0, 32'h22, 32'd2, 5'd11);
    flush_i = 1'b1; in_valid_i = 1'b1; tag_i = 5'd12;
    cyc(acc);
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("flush_valid", {31'd0, out_valid_o}, 32'd0);
    chk("flush_ready", {31'd0, in_ready_o}, 32'd1);
    out_ready_i = 1'b1;
    send(2'd1, 32'hD00, 32'd8, 5'd9);
    chk("flush_d", rd_o, 32'hD);
    idle(2);
    // async reset between edges while output valid
    out_ready_i = 1'b0;
    send(2'd0, 32'h5, 32'd4, 5'd13);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("arst_rd", rd_o, 32'd0);
    chk("arst_tag", {27'd0, tag_o}, 32'd0);
    chk("arst_ready", {31'd0, in_ready_o}, 32'd1);
    sb.delete();
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    send(2'd0, 32'h3, 32'd2, 5'd14);
    chk("post_rst_rd", rd_o, 32'hC);
    idle(2);
    // random stream
    while (ops < 10000 && cycles < 40000) begin
      in_valid_i = ($urandom_range(3) != 0);
      out_ready_i = ($urandom_range(3) != 0);
      flush_i = ($urandom_range(63) == 0);
      op_i = 2'($urandom_range(3));
      rs1_i = $urandom;
      rs2_i = $urandom;
      tag_i = 5'($urandom_range(31));
      r0 = in_ready_o;
      out_ready_i = ~out_ready_i;
      #1;
      chk("ready_comb", {31'd0, in_ready_o}, {31'd0, r0});
      out_ready_i = ~out_ready_i;
      cyc(acc);
      if (acc && !flush_i) ops++;
      cycles++;
    end
    flush_i = 1'b0;
    chk("rand_ops", ops, 32'd10000);
    out_ready_i = 1'b1;
    idle(3);
    chk("drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/ex_shift_stage.md
Name: ex_shift_stage

Overview:
Registered execute-stage shift unit in the CPU datapath. It sits between the ID/EX handoff and the EX/MEM register. It accepts decoded shift operations (SLL/SRL/SRA, register or immediate form) over a valid/ready handshake, computes the 32-bit result, and presents it registered downstream. A one-entry skid buffer keeps in_ready_o a pure register output, so a downstream stall costs no throughput.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
TAG_W, 5, width of the destination-register tag carried alongside the result.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_ni  input  1  reset, asynchronous, active-low
flush_i  input  1  synchronous kill of all in-flight ops (branch mispredict / trap)
in_valid_i  input  1  upstream op valid
in_ready_o  output  1  stage can accept an op this cycle
op_i  input  2  shift_op_e: 0=SLL, 1=SRL, 2=SRA, 3=reserved
rs1_i  input  XLEN  value to shift
rs2_i  input  XLEN  shift amount; only bits [4:0] are used
tag_i  input  TAG_W  destination register index
out_valid_o  output  1  result valid
out_ready_i  input  1  downstream accepts the result
rd_o  output  XLEN  shift result
tag_o  output  TAG_W  tag of the result

Behaviour:
- Reset (async assert, sync deassert): out_valid_o=0, rd_o=0, tag_o=0, in_ready_o=1, skid buffer empty.
- Transfers: input transfer when in_valid_i && in_ready_o; output transfer when out_valid_o && out_ready_i.
- Arithmetic: shamt = rs2_i[4:0]; bits [31:5] are ignored.
  - SLL = rs1 << shamt.
  - SRL = rs1 >> shamt, zero fill.
  - SRA = rs1 >> shamt, sign fill from rs1[31].
  - shamt=0 returns rs1 unchanged.
  - Reserved op 3 returns 0; the tag still passes through.
- Latency: 1 cycle. The result is computed combinationally from the accepted inputs and captured into the output register at the accept edge. out_valid_o rises the next cycle.
- Throughput: 1 op/cycle while out_ready_i=1.
- Output register update rule: load when empty or when the current output transfers this cycle. The source is the skid entry if it is full, otherwise the new input.
- Skid buffer: when an input is accepted and the output register is full and not transferring, the computed result+tag goes into the skid entry.
  - in_ready_o (next) = !skid_full (next).
  - Output ordering is strictly FIFO.
  - No combinational path from out_ready_i to in_ready_o.
- Full condition: output register full and skid full. in_ready_o=0 and no input is accepted.
- Drain: on out_ready_i=1, the skid entry moves to the output register, the skid empties, and in_ready_o returns to 1 the next cycle. A new input arriving in the same cycle is only possible if in_ready_o was 1; see the simultaneous-events rules.
- Simultaneous accept+transfer with skid empty: the new result replaces the output; out_valid_o stays 1.
- Simultaneous accept+transfer with skid full is impossible (in_ready_o=0).
- Outputs hold stable while out_valid_o=1 && out_ready_i=0.
- flush_i=1: at the next edge out_valid_o=0, skid emptied, in_ready_o=1. An input presented in the flush cycle is dropped. flush_i has priority over every other event.
- Reset mid-operation: all in-flight ops are discarded asynchronously and outputs return to reset values immediately.
- rd_o/tag_o hold their last values when out_valid_o=0; the bench must not check them then.

Decomposition:
- Package shift_pkg: XLEN_C=32; SHAMT_W_C=5; typedef enum logic[1:0] shift_op_e {SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_RSVD}; typedef struct packed {logic[XLEN-1:0] data; logic[TAG_W-1:0] tag;} shift_res_t.
- Sub-module shift_core: purely combinational (op, rs1, shamt) -> result. Built as a log-depth 5-stage barrel (16/8/4/2/1) with a fill bit selected by op.
- ex_shift_stage holds only the handshake, output register and skid logic.

Test Plan:
- SRA back-to-back, out_ready_i=1: rs1=0x8000_0000, rs2=4 -> rd_o=0xF800_0000 next cycle. Then SRL with the same operands -> 0x0800_0000. out_valid_o stays high for 2 consecutive cycles.
- Shift-amount masking: SLL rs1=0x0000_0001, rs2=0xFFFF_FFE3 (shamt=3) -> 0x0000_0008. SRA rs1=0xFFFF_FFFF, shamt=31 -> 0xFFFF_FFFF. Reserved op -> 0 with tag preserved.
- Backpressure: out_ready_i=0, issue ops A(tag 1) and B(tag 2) -> in_ready_o falls the cycle after B. Third op C is held. Raise out_ready_i -> outputs A, B, C in order with correct tags, no loss or duplication.
- Flush: with output and skid full, assert flush_i for 1 cycle -> out_valid_o=0 next cycle, in_ready_o=1. The next op D produces only D.
- Async reset mid-stream: deassert rst_ni between clock edges while out_valid_o=1 -> out_valid_o=0 and rd_o=0 immediately. After release, the first op completes with 1-cycle latency.
- Random constrained stream (10k ops, random valid/ready/flush) against a reference model -> results exact, in order, none lost across stalls. in_ready_o never depends combinationally on out_ready_i.
